// File: rtl/s2mm_ring_sched_pkg.sv
// Shared constants and types for the s2mm ring scheduler.
package s2mm_ring_sched_pkg;

    // Engine PS register indices
    localparam logic [1:0] S2MM_REG_ADDR  = 2'd0;
    localparam logic [1:0] S2MM_REG_VALID = 2'd1;
    localparam logic [1:0] S2MM_REG_ERROR = 2'd2;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE,
        PROG,
        WRESP,
        ARMED,
        RDERR,
        REPORT,
        FULL
    } state_t;

endpackage

// File: rtl/s2mm_ring_sched_if.sv
// Bus bundle between the scheduler, the engine PS port, the stream tap
// and the completion consumer. Signal suffixes are from the scheduler's view.
interface s2mm_ring_sched_if #(
    parameter int CNT_W     = 4,
    parameter int LEN_WIDTH = 16
) ();
    logic                 ps_wvalid_o;
    logic [1:0]           ps_waddr_o;
    logic [31:0]          ps_wdata_o;
    logic                 ps_wready_i;
    logic                 ps_wresp_i;
    logic                 ps_arvalid_o;
    logic [1:0]           ps_raddr_o;
    logic [31:0]          ps_rdata_i;
    logic                 ps_rvalid_i;
    logic                 tap_valid_i;
    logic                 tap_ready_i;
    logic                 tap_last_i;
    logic                 cmp_valid_o;
    logic                 cmp_ready_i;
    logic [CNT_W-1:0]     cmp_idx_o;
    logic [LEN_WIDTH-1:0] cmp_bytes_o;
    logic                 cmp_err_o;

    modport master (
        output ps_wvalid_o, ps_waddr_o, ps_wdata_o, ps_arvalid_o, ps_raddr_o,
        output cmp_valid_o, cmp_idx_o, cmp_bytes_o, cmp_err_o,
        input  ps_wready_i, ps_wresp_i, ps_rdata_i, ps_rvalid_i,
        input  tap_valid_i, tap_ready_i, tap_last_i, cmp_ready_i
    );

    modport slave (
        input  ps_wvalid_o, ps_waddr_o, ps_wdata_o, ps_arvalid_o, ps_raddr_o,
        input  cmp_valid_o, cmp_idx_o, cmp_bytes_o, cmp_err_o,
        output ps_wready_i, ps_wresp_i, ps_rdata_i, ps_rvalid_i,
        output tap_valid_i, tap_ready_i, tap_last_i, cmp_ready_i
    );
endinterface

// File: rtl/s2mm_ring_sched_ring_ptr.sv
// Ring position: buffer index and its address, wrapping back to the
// base after the last buffer of the ring.
module s2mm_ring_ptr #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_W-1:0]      count_i,
    input  logic                  adv_i,
    output logic [CNT_W-1:0]      idx_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    logic [ADDR_WIDTH-1:0] base_q, base_d, stride_q, stride_d, addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d, idx_q, idx_d;

    // Next pointer: load restarts at buffer 0, advance steps or wraps
    always_comb begin
        base_d   = base_q;
        stride_d = stride_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        if (load_i) begin
            base_d   = base_i;
            stride_d = stride_i;
            count_d  = count_i;
            idx_d    = '0;
            addr_d   = base_i;
        end else if (adv_i) begin
            if (idx_q == count_q - CNT_W'(1)) begin
                idx_d  = '0;
                addr_d = base_q;
            end else begin
                idx_d  = idx_q + CNT_W'(1);
                addr_d = addr_q + stride_q;
            end
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
        end else begin
            base_q   <= base_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/s2mm_ring_sched.sv
// Arms one s2mm engine buffer-by-buffer around a ring, watches the
// stream for frame ends, reads the error flag and emits one completion
// per frame while never arming a buffer software still owns.
module s2mm_ring_sched
    import s2mm_ring_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BUFS   = 8,
    parameter int LEN_WIDTH  = 16,
    localparam int CNT_W     = $clog2(MAX_BUFS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
    input  logic [CNT_W-1:0]      cfg_count_i,
    input  logic                  rel_i,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  drop_o,
    s2mm_ring_sched_if.master     bus
);
    localparam int BPB   = DATA_WIDTH / 8;
    localparam int PROD_W = LEN_WIDTH + 8;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d, out_q, out_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic                  err_q, err_d, stop_pend_q, stop_pend_d, drop_q, drop_d;
    logic                  load, adv, tap_beat, accept;
    logic [CNT_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [PROD_W-1:0]     prod;
    logic [LEN_WIDTH-1:0]  bytes_sat;
    logic                  rdata_unused;

    s2mm_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .base_i   (cfg_base_i),
        .stride_i (cfg_stride_i),
        .count_i  (cfg_count_i),
        .adv_i    (adv),
        .idx_o    (idx),
        .addr_o   (cur_addr)
    );

    assign tap_beat     = bus.tap_valid_i & bus.tap_ready_i;
    assign accept       = (state_q == REPORT) & bus.cmp_ready_i;
    assign rdata_unused = ^bus.ps_rdata_i[31:1];

    // Byte count of the frame, clipped to the completion field width
    always_comb begin
        prod      = PROD_W'(beats_q) * PROD_W'(BPB);
        bytes_sat = (|prod[PROD_W-1:LEN_WIDTH]) ? '1 : prod[LEN_WIDTH-1:0];
    end

    // Next-state, ownership count, stop/drop tracking
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        beats_d     = beats_q;
        err_d       = err_q;
        stop_pend_d = stop_pend_q;
        drop_d      = drop_q;
        out_d       = out_q;
        load        = 1'b0;
        adv         = 1'b0;

        // A release and an accept in the same cycle cancel out
        if (accept && !rel_i)
            out_d = out_q + CNT_W'(1);
        else if (!accept && rel_i && out_q != '0)
            out_d = out_q - CNT_W'(1);

        if (tap_beat && state_q != ARMED)
            drop_d = 1'b1;
        if (stop_i && state_q != IDLE && state_q != FULL)
            stop_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_i && cfg_count_i != '0) begin
                    state_d     = PROG;
                    count_d     = cfg_count_i;
                    load        = 1'b1;
                    out_d       = '0;
                    drop_d      = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            PROG:  if (bus.ps_wready_i) state_d = WRESP;
            WRESP: begin
                if (bus.ps_wresp_i) begin
                    state_d = ARMED;
                    beats_d = '0;
                end
            end
            ARMED: begin
                if (tap_beat) begin
                    if (beats_q != '1)
                        beats_d = beats_q + LEN_WIDTH'(1);
                    if (bus.tap_last_i)
                        state_d = RDERR;
                end
            end
            RDERR: begin
                if (bus.ps_rvalid_i) begin
                    err_d   = bus.ps_rdata_i[0];
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (bus.cmp_ready_i) begin
                    adv = 1'b1;
                    if (stop_pend_q || stop_i) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else if (out_d == count_q) begin
                        state_d = FULL;
                    end else begin
                        state_d = PROG;
                    end
                end
            end
            FULL: begin
                if (stop_i) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (rel_i) begin
                    state_d = PROG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            beats_q     <= '0;
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            drop_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            beats_q     <= beats_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
            drop_q      <= drop_d;
            out_q       <= out_d;
        end
    end

    // Outputs decoded from state; fields read zero outside their phase
    always_comb begin
        bus.ps_wvalid_o  = (state_q == PROG);
        bus.ps_waddr_o   = S2MM_REG_ADDR;
        bus.ps_wdata_o   = (state_q == PROG) ? 32'(cur_addr) : 32'd0;
        bus.ps_arvalid_o = (state_q == RDERR);
        bus.ps_raddr_o   = (state_q == RDERR) ? S2MM_REG_ERROR : 2'd0;
        bus.cmp_valid_o  = (state_q == REPORT);
        bus.cmp_idx_o    = (state_q == REPORT) ? idx : '0;
        bus.cmp_bytes_o  = (state_q == REPORT) ? bytes_sat : '0;
        bus.cmp_err_o    = (state_q == REPORT) ? err_q : 1'b0;
        busy_o           = (state_q != IDLE);
        full_o           = (state_q == FULL);
        drop_o           = drop_q;
    end
endmodule
